// File: rtl/mcu_pkg.sv
// Shared encodings for the multi-cycle MIPS controller and the ALU:
// opcodes, funct codes, ALU operation codes, FSM states and mux selects.
package mcu_pkg;

  // Instruction opcodes (IR[31:26])
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // ALU operation codes, shared with the ALU
  localparam logic [3:0] ALU_AND  = 4'h0;
  localparam logic [3:0] ALU_OR   = 4'h1;
  localparam logic [3:0] ALU_ADD  = 4'h2;
  localparam logic [3:0] ALU_XOR  = 4'h3;
  localparam logic [3:0] ALU_NOR  = 4'h4;
  localparam logic [3:0] ALU_SLTU = 4'h5;
  localparam logic [3:0] ALU_SUB  = 4'h6;
  localparam logic [3:0] ALU_SLT  = 4'h7;
  localparam logic [3:0] ALU_SLL  = 4'h8;
  localparam logic [3:0] ALU_SLLV = 4'h9;
  localparam logic [3:0] ALU_SRL  = 4'hA;
  localparam logic [3:0] ALU_SRLV = 4'hB;
  localparam logic [3:0] ALU_SRA  = 4'hC;
  localparam logic [3:0] ALU_SRAV = 4'hD;
  localparam logic [3:0] ALU_BAD  = 4'hF;  // unknown funct: ALU answers with BF

  // Operation class requested by the FSM from the ALU decoder
  typedef enum logic [1:0] {
    AOP_ADD   = 2'b00,  // address / PC arithmetic, no overflow trap
    AOP_SUB   = 2'b01,  // BEQ compare
    AOP_FUNCT = 2'b10,  // R-type: decode funct
    AOP_ADDI  = 2'b11   // ADDI: add with overflow trap
  } alu_op_e;

  // FSM states
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_JUMP      = 4'd11,
    S_EXCEPTION = 4'd12
  } state_e;

  // ALU_Src_B selects
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC_Src selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  // Cause register values
  localparam logic CAUSE_OVF = 1'b0;
  localparam logic CAUSE_RI  = 1'b1;

endpackage

// File: rtl/multi_cycle_control_unit_alu_decoder.sv
// ALU control decoder: maps the FSM's operation class and the R-type
// funct field onto the 4-bit ALU code, and flags which operations trap
// on signed overflow.
module alu_decoder
  import mcu_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_cntrl,
  output logic       ovf_en
);

  logic [3:0] fn_code;

  // R-type funct table; unknown functs produce the code that raises BF
  always_comb begin
    fn_code = ALU_BAD;
    case (funct)
      FN_ADD, FN_ADDU: fn_code = ALU_ADD;
      FN_SUB, FN_SUBU: fn_code = ALU_SUB;
      FN_AND:          fn_code = ALU_AND;
      FN_OR:           fn_code = ALU_OR;
      FN_XOR:          fn_code = ALU_XOR;
      FN_NOR:          fn_code = ALU_NOR;
      FN_SLT:          fn_code = ALU_SLT;
      FN_SLTU:         fn_code = ALU_SLTU;
      FN_SLL:          fn_code = ALU_SLL;
      FN_SRL:          fn_code = ALU_SRL;
      FN_SRA:          fn_code = ALU_SRA;
      FN_SLLV:         fn_code = ALU_SLLV;
      FN_SRLV:         fn_code = ALU_SRLV;
      FN_SRAV:         fn_code = ALU_SRAV;
      default:         fn_code = ALU_BAD;
    endcase
  end

  // Pick the final code by operation class; only signed add/sub trap
  always_comb begin
    alu_cntrl = ALU_ADD;
    ovf_en    = 1'b0;
    case (alu_op)
      AOP_ADD:   alu_cntrl = ALU_ADD;
      AOP_SUB:   alu_cntrl = ALU_SUB;
      AOP_FUNCT: begin
        alu_cntrl = fn_code;
        ovf_en    = (funct == FN_ADD) || (funct == FN_SUB);
      end
      AOP_ADDI:  ovf_en = 1'b1;
      default:   alu_cntrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle MIPS main controller. Moore FSM whose outputs decode from
// the state register; only PC_En in BRANCH (ZF_IN) and ALU_Cntrl in
// EXECUTE (Funct) look at inputs. Cause is latched on entry to EXCEPTION.
module multi_cycle_control_unit
  import mcu_pkg::*;
#(
  parameter int OPERAND_WIDTH = 32,
  parameter bit EXC_EN        = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       ZF_IN,
  input  logic       OF_IN,
  input  logic       BF_IN,
  output logic       PC_En,
  output logic       IorD,
  output logic       Mem_Write,
  output logic       IR_Write,
  output logic       Reg_Write,
  output logic       Reg_Dst,
  output logic       Mem_to_Reg,
  output logic       ALU_Src_A,
  output logic [1:0] ALU_Src_B,
  output logic [1:0] PC_Src,
  output logic [3:0] ALU_Cntrl,
  output logic       EPC_Write,
  output logic       Cause_Write,
  output logic       Cause
);

  // Datapath width is documentary; reject nonsense values at elaboration
  if (OPERAND_WIDTH < 1) begin : g_bad_width
    $error("OPERAND_WIDTH must be positive");
  end

  state_e  state_q, state_d;
  logic    cause_q, cause_d;
  alu_op_e alu_op;
  logic    ovf_en;

  logic pc_en, iord, mem_wr, ir_wr, reg_wr, reg_dst, mem_to_reg;
  logic src_a, epc_wr, cause_wr;
  logic [1:0] src_b, pc_src;

  alu_decoder u_alu_dec (
    .alu_op    (alu_op),
    .funct     (Funct),
    .alu_cntrl (ALU_Cntrl),
    .ovf_en    (ovf_en)
  );

  // State and Cause registers; reset parks the FSM in FETCH
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_FETCH;
      cause_q <= CAUSE_OVF;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // Next-state and per-state control decode
  always_comb begin
    state_d    = S_FETCH;
    cause_d    = cause_q;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_wr     = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    src_a      = 1'b0;
    src_b      = SRCB_B;
    pc_src     = PCSRC_ALU;
    alu_op     = AOP_ADD;
    epc_wr     = 1'b0;
    cause_wr   = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_wr   = 1'b1;
        pc_en   = 1'b1;
        src_b   = SRCB_FOUR;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        src_b = SRCB_IMM_SH;  // precompute branch target into ALUOut
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADR;
          OP_R:         state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          OP_J:         state_d = S_JUMP;
          default: begin
            if (EXC_EN) begin
              state_d = S_EXCEPTION;
              cause_d = CAUSE_RI;
            end else begin
              state_d = S_FETCH;
            end
          end
        endcase
      end
      S_MEM_ADR: begin
        src_a   = 1'b1;
        src_b   = SRCB_IMM;
        state_d = (Opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        iord    = 1'b1;
        state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_wr     = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        iord    = 1'b1;
        mem_wr  = 1'b1;
        state_d = S_FETCH;
      end
      S_EXECUTE: begin
        src_a  = 1'b1;
        alu_op = AOP_FUNCT;
        // bad funct outranks overflow when both flags are up
        if (EXC_EN && BF_IN) begin
          state_d = S_EXCEPTION;
          cause_d = CAUSE_RI;
        end else if (EXC_EN && OF_IN && ovf_en) begin
          state_d = S_EXCEPTION;
          cause_d = CAUSE_OVF;
        end else begin
          state_d = S_ALU_WB;
        end
      end
      S_ALU_WB: begin
        reg_dst = 1'b1;
        reg_wr  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        src_a   = 1'b1;
        alu_op  = AOP_SUB;
        pc_src  = PCSRC_ALUOUT;
        pc_en   = ZF_IN;
        state_d = S_FETCH;
      end
      S_ADDI_EXEC: begin
        src_a  = 1'b1;
        src_b  = SRCB_IMM;
        alu_op = AOP_ADDI;
        if (EXC_EN && OF_IN && ovf_en) begin
          state_d = S_EXCEPTION;
          cause_d = CAUSE_OVF;
        end else begin
          state_d = S_ADDI_WB;
        end
      end
      S_ADDI_WB: begin
        reg_wr  = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = PCSRC_JUMP;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      S_EXCEPTION: begin
        epc_wr   = 1'b1;
        cause_wr = 1'b1;
        pc_src   = PCSRC_EXC;
        pc_en    = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Write enables are held off for the whole reset pulse; muxes pass through
  always_comb begin
    PC_En       = pc_en    & ~RST;
    IR_Write    = ir_wr    & ~RST;
    Mem_Write   = mem_wr   & ~RST;
    Reg_Write   = reg_wr   & ~RST;
    EPC_Write   = epc_wr   & ~RST;
    Cause_Write = cause_wr & ~RST;
    IorD        = iord;
    Reg_Dst     = reg_dst;
    Mem_to_Reg  = mem_to_reg;
    ALU_Src_A   = src_a;
    ALU_Src_B   = src_b;
    PC_Src      = pc_src;
    Cause       = cause_q;
  end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Scoreboard bench for multi_cycle_control_unit. Two instances run side
// by side (EXC_EN = 0 and 1), each with its own driver. Each driver turns
// an instruction into the list of per-cycle control words it should
// produce and queues them; one monitor pops and compares every cycle.
module tb_multi_cycle_control_unit;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [3:0] alu_cntrl;
    logic       epc_write;
    logic       cause_write;
    logic       cause;
  } out_t;

  logic clk;
  out_t exp_q [2][$];
  out_t act   [2];
  logic mon_on [2];
  logic done_a [2];
  int   checks;
  int   errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ALU code an R-type funct should select
  function automatic logic [3:0] ref_alu(input logic [5:0] f);
    case (f)
      6'h20, 6'h21: return 4'h2;
      6'h22, 6'h23: return 4'h6;
      6'h24: return 4'h0;
      6'h25: return 4'h1;
      6'h26: return 4'h3;
      6'h27: return 4'h4;
      6'h2A: return 4'h7;
      6'h2B: return 4'h5;
      6'h00: return 4'h8;
      6'h02: return 4'hA;
      6'h03: return 4'hC;
      6'h04: return 4'h9;
      6'h06: return 4'hB;
      6'h07: return 4'hD;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [5:0] pick_fn(input int i);
    case (i)
      0: return 6'h20;  1: return 6'h21;  2: return 6'h22;  3: return 6'h23;
      4: return 6'h24;  5: return 6'h25;  6: return 6'h26;  7: return 6'h27;
      8: return 6'h2A;  9: return 6'h2B; 10: return 6'h00; 11: return 6'h02;
      12: return 6'h03; 13: return 6'h04; 14: return 6'h06; default: return 6'h07;
    endcase
  endfunction

  function automatic bit legal_op(input logic [5:0] op);
    return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
           op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam bit EXC = (g == 1);

    logic       rst_l, on_l, done_l;
    logic [5:0] opc, fn;
    logic       zf, of, bf;
    logic       pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg;
    logic       alu_src_a, epc_write, cause_write, cause;
    logic [1:0] alu_src_b, pc_src;
    logic [3:0] alu_cntrl;
    logic       cause_m;

    multi_cycle_control_unit #(.OPERAND_WIDTH(32), .EXC_EN(EXC)) u_dut (
      .CLK(clk), .RST(rst_l), .Opcode(opc), .Funct(fn),
      .ZF_IN(zf), .OF_IN(of), .BF_IN(bf),
      .PC_En(pc_en), .IorD(iord), .Mem_Write(mem_write), .IR_Write(ir_write),
      .Reg_Write(reg_write), .Reg_Dst(reg_dst), .Mem_to_Reg(mem_to_reg),
      .ALU_Src_A(alu_src_a), .ALU_Src_B(alu_src_b), .PC_Src(pc_src),
      .ALU_Cntrl(alu_cntrl), .EPC_Write(epc_write), .Cause_Write(cause_write),
      .Cause(cause)
    );

    assign act[g] = {pc_en, iord, mem_write, ir_write, reg_write, reg_dst,
                     mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_cntrl,
                     epc_write, cause_write, cause};
    assign mon_on[g] = on_l;
    assign done_a[g] = done_l;

    // Idle control word: nothing enabled, ALU adding, Cause held
    function automatic out_t idle();
      out_t r;
      r = '0;
      r.alu_cntrl = 4'h2;
      r.cause     = cause_m;
      return r;
    endfunction

    function automatic out_t rst_word();
      out_t r;
      r = '0;
      r.alu_src_b = 2'b01;
      r.alu_cntrl = 4'h2;
      return r;
    endfunction

    task automatic take_exc(input logic c);
      out_t r;
      cause_m = c;
      r = idle();
      r.epc_write = 1'b1; r.cause_write = 1'b1;
      r.pc_src = 2'b11;   r.pc_en = 1'b1;
      exp_q[g].push_back(r);
    endtask

    // Expected cycle-by-cycle behaviour of one instruction
    task automatic model(input logic [5:0] op, input logic [5:0] f,
                         input logic z, input logic o, input logic b,
                         output int n);
      out_t r;
      int   s;
      s = exp_q[g].size();
      r = idle(); r.ir_write = 1'b1; r.pc_en = 1'b1; r.alu_src_b = 2'b01;
      exp_q[g].push_back(r);
      r = idle(); r.alu_src_b = 2'b11;
      exp_q[g].push_back(r);
      if (op == 6'b100011 || op == 6'b101011) begin
        r = idle(); r.alu_src_a = 1'b1; r.alu_src_b = 2'b10;
        exp_q[g].push_back(r);
        if (op == 6'b100011) begin
          r = idle(); r.iord = 1'b1;
          exp_q[g].push_back(r);
          r = idle(); r.reg_write = 1'b1; r.mem_to_reg = 1'b1;
          exp_q[g].push_back(r);
        end else begin
          r = idle(); r.iord = 1'b1; r.mem_write = 1'b1;
          exp_q[g].push_back(r);
        end
      end else if (op == 6'b000000) begin
        r = idle(); r.alu_src_a = 1'b1; r.alu_cntrl = ref_alu(f);
        exp_q[g].push_back(r);
        if (EXC && b)                                      take_exc(1'b1);
        else if (EXC && o && (f == 6'h20 || f == 6'h22))  take_exc(1'b0);
        else begin
          r = idle(); r.reg_dst = 1'b1; r.reg_write = 1'b1;
          exp_q[g].push_back(r);
        end
      end else if (op == 6'b000100) begin
        r = idle(); r.alu_src_a = 1'b1; r.alu_cntrl = 4'h6;
        r.pc_src = 2'b01; r.pc_en = z;
        exp_q[g].push_back(r);
      end else if (op == 6'b001000) begin
        r = idle(); r.alu_src_a = 1'b1; r.alu_src_b = 2'b10;
        exp_q[g].push_back(r);
        if (EXC && o) take_exc(1'b0);
        else begin
          r = idle(); r.reg_write = 1'b1;
          exp_q[g].push_back(r);
        end
      end else if (op == 6'b000010) begin
        r = idle(); r.pc_src = 2'b10; r.pc_en = 1'b1;
        exp_q[g].push_back(r);
      end else if (EXC) begin
        take_exc(1'b1);
      end
      n = exp_q[g].size() - s;
    endtask

    // Called just after a rising edge with the FSM about to be in FETCH
    task automatic issue(input logic [5:0] op, input logic [5:0] f,
                         input logic z, input logic o, input logic b);
      int n;
      opc = op; fn = f; zf = z; of = o; bf = b;
      model(op, f, z, o, b, n);
      repeat (n) @(posedge clk);
      #1;
    endtask

    // Start an LW and pull reset while it sits in MEM_READ
    task automatic reset_mid_lw();
      int n;
      opc = 6'b100011; fn = 6'h00; zf = 1'b0; of = 1'b0; bf = 1'b0;
      model(6'b100011, 6'h00, 1'b0, 1'b0, 1'b0, n);
      void'(exp_q[g].pop_back());  // MEM_WB never happens
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1 rst_l = 1'b1;
      cause_m = 1'b0;
      exp_q[g].push_back(rst_word());
      exp_q[g].push_back(rst_word());
      @(negedge clk);
      @(negedge clk);
      @(posedge clk);
      #1 rst_l = 1'b0;
    endtask

    initial begin
      logic [5:0] op, f;
      rst_l = 1'b1; on_l = 1'b1; done_l = 1'b0; cause_m = 1'b0;
      opc = '0; fn = '0; zf = 1'b0; of = 1'b0; bf = 1'b0;
      exp_q[g].push_back(rst_word());
      exp_q[g].push_back(rst_word());
      @(negedge clk);
      @(negedge clk);
      @(posedge clk);
      #1 rst_l = 1'b0;

      issue(6'b100011, 6'h15, 1'b0, 1'b0, 1'b0);  // LW
      reset_mid_lw();
      issue(6'b000000, 6'h2A, 1'b0, 1'b0, 1'b0);  // SLT
      issue(6'b000000, 6'h07, 1'b0, 1'b0, 1'b0);  // SRAV
      issue(6'b000100, 6'h00, 1'b1, 1'b0, 1'b0);  // BEQ taken
      issue(6'b000100, 6'h00, 1'b0, 1'b0, 1'b0);  // BEQ not taken
      issue(6'b000000, 6'h20, 1'b0, 1'b1, 1'b0);  // ADD overflow
      issue(6'b000000, 6'h21, 1'b0, 1'b1, 1'b0);  // ADDU overflow ignored
      issue(6'b111111, 6'h00, 1'b0, 1'b0, 1'b0);  // reserved opcode
      issue(6'b000000, 6'h3F, 1'b0, 1'b0, 1'b1);  // bad funct
      issue(6'b101011, 6'h00, 1'b0, 1'b0, 1'b0);  // SW
      issue(6'b000010, 6'h00, 1'b0, 1'b0, 1'b0);  // J
      issue(6'b001000, 6'h00, 1'b0, 1'b1, 1'b0);  // ADDI overflow
      issue(6'b001000, 6'h00, 1'b0, 1'b0, 1'b0);  // ADDI
      issue(6'b000000, 6'h22, 1'b0, 1'b1, 1'b0);  // SUB overflow
      issue(6'b000000, 6'h23, 1'b0, 1'b1, 1'b0);  // SUBU overflow ignored

      for (int i = 0; i < 150; i++) begin
        case ($urandom_range(0, 7))
          0: op = 6'b100011;
          1: op = 6'b101011;
          2: op = 6'b000100;
          3: op = 6'b001000;
          4: op = 6'b000010;
          5: begin
            do op = 6'($urandom); while (legal_op(op));
          end
          default: op = 6'b000000;
        endcase
        if ($urandom_range(0, 3) != 0) f = pick_fn($urandom_range(0, 15));
        else                           f = 6'($urandom);
        issue(op, f, 1'($urandom), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 3) == 0));
      end
      on_l   = 1'b0;
      done_l = 1'b1;
    end
  end

  // Monitor: one expected control word per DUT per cycle, sampled mid-cycle
  initial begin
    out_t e;
    int   cyc;
    bit   fin;
    checks = 0; errors = 0; cyc = 0; fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (mon_on[d]) begin
          checks++;
          if (exp_q[d].size() == 0) begin
            errors++;
            $display("FAIL exc_en%0d cycle %0d: nothing expected, got %h", d, cyc, act[d]);
          end else begin
            e = exp_q[d].pop_front();
            if (act[d] !== e) begin
              errors++;
              $display("FAIL exc_en%0d cycle %0d ctrl: got %h expected %h", d, cyc, act[d], e);
            end
          end
        end
      end
      if (done_a[0] && done_a[1]) begin
        for (int d = 0; d < 2; d++) begin
          checks++;
          if (exp_q[d].size() != 0) begin
            errors++;
            $display("FAIL exc_en%0d leftover: got %0d words, expected 0", d, exp_q[d].size());
          end
        end
        fin = 1'b1;
      end else if (cyc > 20000) begin
        checks++;
        errors++;
        $display("FAIL timeout: got %0d cycles, expected drivers done", cyc);
        fin = 1'b1;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
